// File: rtl/exec_controller.sv
// Run/stop execution controller for the processor front panel.
// A debounced run/stop button moves the machine between STOP and RUN, the
// control unit's halt flag parks it in HALTED until reset, and every accepted
// press is counted for the seven-segment display.
// Optional feature: define EXEC_STEP_EN to add a single-step button (step_n)
// that runs the machine for one phase-counter revolution (STEP state).

// Synchronizer plus level debouncer with a registered falling-edge press event.
module exec_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             prev_q, prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has been seen DEBOUNCE_CYCLES times in a row.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    prev_d  = level_q;
    press_d = prev_q & ~level_q;
  end

  // Idle level is "released" so a reset never fabricates a press.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       exec_n,
`ifdef EXEC_STEP_EN
  input  logic       step_n,
`endif
  input  logic       halt,
  input  logic [2:0] phase,
  output logic       exec,
  output logic       start_pulse,
  output logic [1:0] state,
  output logic [3:0] press_cnt
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_STEP   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic       phase_seen_q, phase_seen_d;
  logic [3:0] press_cnt_q, press_cnt_d;
  logic       exec_press;
  logic       step_press;

  exec_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_exec_db (
    .clock(clock),
    .reset(reset),
    .btn_n(exec_n),
    .press(exec_press)
  );

`ifdef EXEC_STEP_EN
  exec_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_db (
    .clock(clock),
    .reset(reset),
    .btn_n(step_n),
    .press(step_press)
  );
`else
  assign step_press = 1'b0;
`endif

  // Next state: halt beats a simultaneous press in RUN; HALTED only leaves via reset.
  always_comb begin
    state_d      = state_q;
    phase_seen_d = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (exec_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (exec_press) begin
          state_d = ST_STOP;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_STEP: begin
        if (phase_seen_q && (phase == 3'd0)) begin
          state_d = ST_STOP;
        end else begin
          phase_seen_d = phase_seen_q | (phase != 3'd0);
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
    start_d     = ((state_d == ST_RUN) || (state_d == ST_STEP)) && (state_d != state_q);
    press_cnt_d = press_cnt_q + {3'b000, exec_press};
  end

  // State, entry pulse and press counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_STOP;
      start_q      <= 1'b0;
      phase_seen_q <= 1'b0;
      press_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      phase_seen_q <= phase_seen_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign exec        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign start_pulse = start_q;
  assign state       = state_q;
  assign press_cnt   = press_cnt_q;

endmodule
